mode_controller: RTL
====================

// Module: mode_controller
// PURPOSE
//  Central sequencer for the clock/stopwatch/timer display system. Owns the shared display and
//  start button: cycles the active mode, routes start presses to the active counter, and
//  pre-empts the display with a timed, blinking alarm when the timer expires. Sits between
//  the debouncers and the clock_top/stopwatch_top/timer_top/display_control instances.
//  Replaces count_mode.
// PARAMETERS
//  ALARM_MS  10000  alarm auto-dismiss time, in tick_1khz pulses
//  BLINK_MS  250    alarm_led half-period, in tick_1khz pulses
//  CNT_W     14     width of the alarm and blink counters; must hold ALARM_MS-1
// PORTS
//  clk_100Mhz    in   1  system clock
//  reset_in      in   1  asynchronous, active-low reset
//  tick_1khz     in   1  one-cycle enable at 1 kHz, synchronous to clk_100Mhz
//  mode_btn      in   1  debounced mode button (level)
//  start_btn     in   1  debounced start button (level)
//  timer_done    in   1  level from timer_top; high while timer reads zero after a run
//  mode_select   out  2  display mode: 00 clock, 01 stopwatch, 10 timer; 11 never driven
//  sw_start      out  1  one-cycle start/stop toggle pulse to stopwatch_top
//  timer_start   out  1  one-cycle start/stop toggle pulse to timer_top
//  timer_set_en  out  1  high in S_TIMER only; gates hr/min/sec increments into timer_top
//  alarm_active  out  1  high in S_ALARM
//  alarm_led     out  1  blinks during alarm, otherwise 0
// BEHAVIOUR
//  Reset (reset_in=0, async):
//  - state=S_CLOCK, saved=S_CLOCK, counters=0, all outputs 0 (mode_select=00).
//  - Edge registers mode_q, start_q and done_q reset to 1: a level held through reset
//    produces no event.
//  Edge detection:
//  - rise_x = x & ~x_q, evaluated each clk_100Mhz edge.
//  - All outputs are registered and update at the same edge where the rise is sampled
//    (latency of 1 clock from the input level).
//  FSM states:
//  - S_CLOCK: mode rise -> S_SW. Start rise is ignored.
//  - S_SW: mode rise -> S_TIMER. Start rise -> sw_start=1 for exactly one cycle.
//  - S_TIMER: mode rise -> S_CLOCK. Start rise -> timer_start=1 for exactly one cycle.
//  - Any non-alarm state: done rise -> S_ALARM; saved <= current state.
//  - S_ALARM:
//    - mode_select=10.
//    - Any mode or start rise acknowledges -> state <= saved. The press is consumed: no
//      pulse, no mode advance.
//    - Auto-exit to saved when the alarm counter equals ALARM_MS-1 on a tick.
//  Alarm timing:
//  - On entry: alarm_cnt=0, blink_cnt=0, alarm_led=1.
//  - Counters advance only on tick_1khz.
//  - blink_cnt==BLINK_MS-1 on a tick -> toggle alarm_led and wrap blink_cnt to 0.
//  - On exit: alarm_led=0 and counters cleared.
//  Boundaries:
//  - done rise and mode rise in the same cycle: alarm wins; saved = pre-advance state;
//    mode press is dropped.
//  - done rise while in S_ALARM: restart alarm_cnt and blink_cnt; saved is unchanged.
//  - Ack and timeout in the same cycle: single return to saved, no double action.
//  - Start rise and mode rise in the same cycle (non-alarm): the pulse goes to the
//    pre-advance mode's counter, then the mode advances.
//  - Held buttons generate exactly one event per press.
//  - Reset asserted mid-alarm: immediate return to the reset state.
// STRUCTURE
//  - Shared header mode_defs.vh:
//    - MODE_CLOCK=2'b00, MODE_SW=2'b01, MODE_TIMER=2'b10, also used by display_control.
//    - FSM state encodings.
//  - One sub-module, rise_detect: async active-low reset, reset value 1, outputs the rise
//    pulse. Instantiated three times (mode, start, done).
// TESTING (bench: ALARM_MS=20, BLINK_MS=5, tick every 10 clocks)
//  - Release reset with mode_btn held high -> no mode change; release, then 3 presses ->
//    mode_select 01, 10, 00.
//  - In S_SW, press start -> sw_start high exactly 1 cycle, timer_start stays 0. In
//    S_CLOCK, press start -> no pulses.
//  - In S_SW, raise timer_done -> mode_select=10, alarm_active=1, alarm_led toggles every
//    5 ticks. After 20 ticks -> returns to mode_select=01, led 0.
//  - In alarm, press start -> exits to saved mode with no sw_start/timer_start pulse.
//  - timer_done and mode rise in the same cycle from S_CLOCK -> S_ALARM; after ack ->
//    mode_select=00.
//  - Assert reset_in low mid-alarm, asynchronously between clock edges -> all outputs 0
//    immediately, S_CLOCK.

Source files
------------

// File: rtl/mode_controller_pkg.sv
// Shared mode and state encodings for the display mode sequencer.
// Also consumed by display_control for mode_select decoding.
package mode_controller_pkg;

    localparam logic [1:0] MODE_CLOCK = 2'b00;
    localparam logic [1:0] MODE_SW    = 2'b01;
    localparam logic [1:0] MODE_TIMER = 2'b10;

    typedef enum logic [1:0] {
        S_CLOCK = 2'b00,
        S_SW    = 2'b01,
        S_TIMER = 2'b10,
        S_ALARM = 2'b11
    } state_t;

    function automatic logic [1:0] mode_of(input state_t s);
        logic [1:0] m;
        m = MODE_CLOCK;
        unique case (s)
            S_CLOCK: m = MODE_CLOCK;
            S_SW:    m = MODE_SW;
            S_TIMER: m = MODE_TIMER;
            S_ALARM: m = MODE_TIMER;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mode_controller_rise_detect.sv
// Rising-edge detector; history resets high so a level held
// through reset does not produce an event.
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic rise
);

    logic q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b1;
        end else begin
            q <= level;
        end
    end

    assign rise = level & ~q;

endmodule

// File: rtl/mode_controller.sv
// Display mode sequencer: cycles modes, routes start presses,
// and pre-empts the display with a blinking alarm on timer expiry.
module mode_controller
    import mode_controller_pkg::*;
#(
    parameter int ALARM_MS = 10000,
    parameter int BLINK_MS = 250,
    parameter int CNT_W    = 14
) (
    input  logic       clk_100Mhz,
    input  logic       reset_in,
    input  logic       tick_1khz,
    input  logic       mode_btn,
    input  logic       start_btn,
    input  logic       timer_done,
    output logic [1:0] mode_select,
    output logic       sw_start,
    output logic       timer_start,
    output logic       timer_set_en,
    output logic       alarm_active,
    output logic       alarm_led
);

    localparam logic [CNT_W-1:0] ALARM_LAST = CNT_W'(ALARM_MS - 1);
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_MS - 1);

    logic mode_rise;
    logic start_rise;
    logic done_rise;

    rise_detect u_mode (
        .clk   (clk_100Mhz),
        .rst_n (reset_in),
        .level (mode_btn),
        .rise  (mode_rise)
    );

    rise_detect u_start (
        .clk   (clk_100Mhz),
        .rst_n (reset_in),
        .level (start_btn),
        .rise  (start_rise)
    );

    rise_detect u_done (
        .clk   (clk_100Mhz),
        .rst_n (reset_in),
        .level (timer_done),
        .rise  (done_rise)
    );

    state_t           state;
    state_t           saved;
    logic [CNT_W-1:0] alarm_cnt;
    logic [CNT_W-1:0] blink_cnt;

    logic ack;
    logic timeout;

    assign ack     = mode_rise | start_rise;
    assign timeout = tick_1khz && (alarm_cnt == ALARM_LAST);

    always_ff @(posedge clk_100Mhz or negedge reset_in) begin
        if (!reset_in) begin
            state        <= S_CLOCK;
            saved        <= S_CLOCK;
            alarm_cnt    <= '0;
            blink_cnt    <= '0;
            mode_select  <= MODE_CLOCK;
            sw_start     <= 1'b0;
            timer_start  <= 1'b0;
            timer_set_en <= 1'b0;
            alarm_active <= 1'b0;
            alarm_led    <= 1'b0;
        end else begin
            sw_start    <= 1'b0;
            timer_start <= 1'b0;
            if (state == S_ALARM) begin
                // Acknowledge and timeout share one exit path.
                if (ack || timeout) begin
                    state        <= saved;
                    alarm_cnt    <= '0;
                    blink_cnt    <= '0;
                    alarm_led    <= 1'b0;
                    alarm_active <= 1'b0;
                    mode_select  <= mode_of(saved);
                    timer_set_en <= (saved == S_TIMER);
                end else if (done_rise) begin
                    alarm_cnt <= '0;
                    blink_cnt <= '0;
                    alarm_led <= 1'b1;
                end else if (tick_1khz) begin
                    alarm_cnt <= alarm_cnt + 1'b1;
                    if (blink_cnt == BLINK_LAST) begin
                        blink_cnt <= '0;
                        alarm_led <= ~alarm_led;
                    end else begin
                        blink_cnt <= blink_cnt + 1'b1;
                    end
                end
            end else if (done_rise) begin
                state        <= S_ALARM;
                saved        <= state;
                alarm_cnt    <= '0;
                blink_cnt    <= '0;
                alarm_led    <= 1'b1;
                alarm_active <= 1'b1;
                mode_select  <= MODE_TIMER;
                timer_set_en <= 1'b0;
            end else begin
                if (start_rise) begin
                    sw_start    <= (state == S_SW);
                    timer_start <= (state == S_TIMER);
                end
                if (mode_rise) begin
                    unique case (state)
                        S_CLOCK: begin
                            state        <= S_SW;
                            mode_select  <= MODE_SW;
                            timer_set_en <= 1'b0;
                        end
                        S_SW: begin
                            state        <= S_TIMER;
                            mode_select  <= MODE_TIMER;
                            timer_set_en <= 1'b1;
                        end
                        default: begin
                            state        <= S_CLOCK;
                            mode_select  <= MODE_CLOCK;
                            timer_set_en <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule
